// File: rtl/snd_cmd_mailbox.sv
// Main-CPU to sound-CPU command mailbox: DEPTH-entry command FIFO with busy,
// overflow and occupancy status, merged with an edge-triggered IRQ controller.
module snd_cmd_mailbox #(
    parameter int            DW        = 8,
    parameter int            DEPTH     = 4,
    parameter int            NSRC      = 2,
    parameter logic [DW-1:0] EMPTY_VAL = {DW{1'b1}}
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_wr,
    input  logic [DW-1:0]            cmd_din,
    input  logic                     rd_stb,
    input  logic                     clr_stb,
    input  logic [NSRC-1:0]          irq_src,
    input  logic [NSRC:0]            irq_ack,
    output logic [DW-1:0]            rd_data,
    output logic                     snd_busy,
    output logic                     cmd_full,
    output logic                     cmd_ovf,
    output logic [$clog2(DEPTH):0]   cmd_count,
    output logic [NSRC:0]            irq_pend,
    output logic                     int_n
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DW-1:0]   mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            ovf;
    logic [NSRC:0]   pend;
    logic            cmd_wr_q;
    logic [NSRC-1:0] irq_src_q;

    logic            push_req;
    logic [NSRC-1:0] src_edge;
    logic            is_empty;
    logic            is_full;
    logic            pop_ok;
    logic            push_ok;
    logic            wr_en;
    logic [NSRC:0]   pend_set;

    // Edge-detect registers track their inputs even in reset, so a level
    // already high at reset release is not mistaken for a new edge.
    always_ff @(posedge clk) begin
        cmd_wr_q  <= cmd_wr;
        irq_src_q <= irq_src;
    end

    assign push_req = cmd_wr & ~cmd_wr_q;
    assign src_edge = irq_src & ~irq_src_q;

    assign is_empty = (count == '0);
    assign is_full  = (count == FULL_CNT);
    assign pop_ok   = rd_stb & ~is_empty;
    // A push into a full FIFO is still accepted when a pop frees a slot in the same cycle.
    assign push_ok  = push_req & (~is_full | pop_ok);
    assign wr_en    = push_ok & ~clr_stb;
    assign pend_set = {src_edge, wr_en};

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= cmd_din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else if (clr_stb) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push_ok && !pop_ok) begin
                count <= count + CW'(1);
            end else if (pop_ok && !push_ok) begin
                count <= count - CW'(1);
            end
            if (push_req && !push_ok) begin
                ovf <= 1'b1;
            end
        end
    end

    // A new event outranks an ack arriving in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend <= '0;
        end else begin
            pend <= (pend & ~irq_ack) | pend_set;
        end
    end

    assign rd_data   = is_empty ? EMPTY_VAL : mem[rd_ptr];
    assign snd_busy  = ~is_empty;
    assign cmd_full  = is_full;
    assign cmd_ovf   = ovf;
    assign cmd_count = count;
    assign irq_pend  = pend;
    assign int_n     = ~|pend;

endmodule

// File: tb/tb_snd_cmd_mailbox.sv
// Directed bench for snd_cmd_mailbox: FIFO vector table plus reset and IRQ sequences.
module tb_snd_cmd_mailbox;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_wr;
    logic [7:0] cmd_din;
    logic       rd_stb;
    logic       clr_stb;
    logic [1:0] irq_src;
    logic [2:0] irq_ack;
    logic [7:0] rd_data;
    logic       snd_busy;
    logic       cmd_full;
    logic       cmd_ovf;
    logic [2:0] cmd_count;
    logic [2:0] irq_pend;
    logic       int_n;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    snd_cmd_mailbox #(.DW(8), .DEPTH(4), .NSRC(2), .EMPTY_VAL(8'hFF)) dut (
        .clk(clk), .rst(rst), .cmd_wr(cmd_wr), .cmd_din(cmd_din),
        .rd_stb(rd_stb), .clr_stb(clr_stb), .irq_src(irq_src), .irq_ack(irq_ack),
        .rd_data(rd_data), .snd_busy(snd_busy), .cmd_full(cmd_full), .cmd_ovf(cmd_ovf),
        .cmd_count(cmd_count), .irq_pend(irq_pend), .int_n(int_n)
    );

    typedef struct {
        logic       wr;
        logic [7:0] din;
        logic       rd;
        logic       clr;
        logic [2:0] ack;
        logic [7:0] e_rd;
        logic       e_busy;
        logic       e_full;
        logic       e_ovf;
        logic [2:0] e_cnt;
        logic [2:0] e_pend;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic wr, logic [7:0] din, logic rd, logic clr,
                                logic [2:0] ack, logic [7:0] e_rd, logic e_busy,
                                logic e_full, logic e_ovf, logic [2:0] e_cnt,
                                logic [2:0] e_pend);
        vec_t v;
        v.wr = wr; v.din = din; v.rd = rd; v.clr = clr; v.ack = ack;
        v.e_rd = e_rd; v.e_busy = e_busy; v.e_full = e_full; v.e_ovf = e_ovf;
        v.e_cnt = e_cnt; v.e_pend = e_pend;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {14'd0, rd_data, snd_busy, cmd_full, cmd_ovf, cmd_count, irq_pend, int_n};
    endfunction

    function automatic logic [31:0] exp_outs(vec_t v);
        return {14'd0, v.e_rd, v.e_busy, v.e_full, v.e_ovf, v.e_cnt, v.e_pend, ~|v.e_pend};
    endfunction

    task automatic idle();
        cmd_wr = 0; cmd_din = 8'h00; rd_stb = 0; clr_stb = 0; irq_src = 2'b00; irq_ack = 3'b000;
    endtask

    initial begin
        // wr  din    rd clr ack     rd_data busy full ovf cnt pend
        tbl.push_back(mk(1, 8'h3A, 0, 0, 3'b000, 8'h3A, 1, 0, 0, 3'd1, 3'b001));
        tbl.push_back(mk(0, 8'h00, 0, 0, 3'b001, 8'h3A, 1, 0, 0, 3'd1, 3'b000));
        tbl.push_back(mk(0, 8'h00, 1, 0, 3'b000, 8'hFF, 0, 0, 0, 3'd0, 3'b000));
        tbl.push_back(mk(1, 8'h01, 0, 0, 3'b000, 8'h01, 1, 0, 0, 3'd1, 3'b001));
        tbl.push_back(mk(0, 8'h00, 0, 0, 3'b000, 8'h01, 1, 0, 0, 3'd1, 3'b001));
        tbl.push_back(mk(1, 8'h02, 0, 0, 3'b000, 8'h01, 1, 0, 0, 3'd2, 3'b001));
        tbl.push_back(mk(0, 8'h00, 0, 0, 3'b000, 8'h01, 1, 0, 0, 3'd2, 3'b001));
        tbl.push_back(mk(1, 8'h03, 0, 0, 3'b000, 8'h01, 1, 0, 0, 3'd3, 3'b001));
        tbl.push_back(mk(0, 8'h00, 0, 0, 3'b000, 8'h01, 1, 0, 0, 3'd3, 3'b001));
        tbl.push_back(mk(1, 8'h04, 0, 0, 3'b000, 8'h01, 1, 1, 0, 3'd4, 3'b001));
        tbl.push_back(mk(0, 8'h00, 0, 0, 3'b000, 8'h01, 1, 1, 0, 3'd4, 3'b001));
        tbl.push_back(mk(1, 8'h05, 0, 0, 3'b000, 8'h01, 1, 1, 1, 3'd4, 3'b001));
        tbl.push_back(mk(0, 8'h00, 0, 0, 3'b000, 8'h01, 1, 1, 1, 3'd4, 3'b001));
        tbl.push_back(mk(0, 8'h00, 1, 0, 3'b000, 8'h02, 1, 0, 1, 3'd3, 3'b001));
        tbl.push_back(mk(0, 8'h00, 1, 0, 3'b000, 8'h03, 1, 0, 1, 3'd2, 3'b001));
        tbl.push_back(mk(0, 8'h00, 1, 0, 3'b000, 8'h04, 1, 0, 1, 3'd1, 3'b001));
        tbl.push_back(mk(0, 8'h00, 1, 0, 3'b000, 8'hFF, 0, 0, 1, 3'd0, 3'b001));
        tbl.push_back(mk(0, 8'h00, 1, 0, 3'b000, 8'hFF, 0, 0, 1, 3'd0, 3'b001));
        tbl.push_back(mk(0, 8'h00, 0, 1, 3'b000, 8'hFF, 0, 0, 0, 3'd0, 3'b001));
        tbl.push_back(mk(0, 8'h00, 0, 0, 3'b001, 8'hFF, 0, 0, 0, 3'd0, 3'b000));
        tbl.push_back(mk(1, 8'hA1, 0, 0, 3'b000, 8'hA1, 1, 0, 0, 3'd1, 3'b001));
        tbl.push_back(mk(0, 8'h00, 0, 0, 3'b000, 8'hA1, 1, 0, 0, 3'd1, 3'b001));
        tbl.push_back(mk(1, 8'hA2, 0, 0, 3'b000, 8'hA1, 1, 0, 0, 3'd2, 3'b001));
        tbl.push_back(mk(0, 8'h00, 0, 0, 3'b000, 8'hA1, 1, 0, 0, 3'd2, 3'b001));
        tbl.push_back(mk(1, 8'hA3, 0, 0, 3'b000, 8'hA1, 1, 0, 0, 3'd3, 3'b001));
        tbl.push_back(mk(0, 8'h00, 0, 0, 3'b000, 8'hA1, 1, 0, 0, 3'd3, 3'b001));
        tbl.push_back(mk(1, 8'hA4, 0, 0, 3'b000, 8'hA1, 1, 1, 0, 3'd4, 3'b001));
        tbl.push_back(mk(0, 8'h00, 0, 0, 3'b000, 8'hA1, 1, 1, 0, 3'd4, 3'b001));
        tbl.push_back(mk(1, 8'h10, 1, 0, 3'b000, 8'hA2, 1, 1, 0, 3'd4, 3'b001));
        tbl.push_back(mk(0, 8'h00, 0, 0, 3'b000, 8'hA2, 1, 1, 0, 3'd4, 3'b001));
        tbl.push_back(mk(1, 8'h11, 1, 0, 3'b000, 8'hA3, 1, 1, 0, 3'd4, 3'b001));
        tbl.push_back(mk(0, 8'h00, 0, 0, 3'b000, 8'hA3, 1, 1, 0, 3'd4, 3'b001));
        tbl.push_back(mk(1, 8'h12, 1, 0, 3'b000, 8'hA4, 1, 1, 0, 3'd4, 3'b001));
        tbl.push_back(mk(0, 8'h00, 0, 0, 3'b000, 8'hA4, 1, 1, 0, 3'd4, 3'b001));
        tbl.push_back(mk(1, 8'h13, 1, 0, 3'b000, 8'h10, 1, 1, 0, 3'd4, 3'b001));
        tbl.push_back(mk(0, 8'h00, 1, 0, 3'b000, 8'h11, 1, 0, 0, 3'd3, 3'b001));
        tbl.push_back(mk(0, 8'h00, 1, 0, 3'b000, 8'h12, 1, 0, 0, 3'd2, 3'b001));
        tbl.push_back(mk(0, 8'h00, 1, 0, 3'b000, 8'h13, 1, 0, 0, 3'd1, 3'b001));
        tbl.push_back(mk(0, 8'h00, 1, 0, 3'b000, 8'hFF, 0, 0, 0, 3'd0, 3'b001));
        tbl.push_back(mk(1, 8'h20, 1, 0, 3'b000, 8'h20, 1, 0, 0, 3'd1, 3'b001));
        tbl.push_back(mk(0, 8'h00, 0, 0, 3'b001, 8'h20, 1, 0, 0, 3'd1, 3'b000));
        tbl.push_back(mk(1, 8'h21, 0, 0, 3'b000, 8'h20, 1, 0, 0, 3'd2, 3'b001));
        tbl.push_back(mk(0, 8'h00, 0, 0, 3'b001, 8'h20, 1, 0, 0, 3'd2, 3'b000));
        tbl.push_back(mk(1, 8'h77, 0, 1, 3'b000, 8'hFF, 0, 0, 0, 3'd0, 3'b000));
        tbl.push_back(mk(0, 8'h00, 1, 0, 3'b000, 8'hFF, 0, 0, 0, 3'd0, 3'b000));
        tbl.push_back(mk(1, 8'h30, 0, 0, 3'b000, 8'h30, 1, 0, 0, 3'd1, 3'b001));
        tbl.push_back(mk(0, 8'h00, 0, 0, 3'b000, 8'h30, 1, 0, 0, 3'd1, 3'b001));
        tbl.push_back(mk(1, 8'h31, 0, 0, 3'b001, 8'h30, 1, 0, 0, 3'd2, 3'b001));

        // Reset held with inputs high: nothing may fire on release.
        rst = 1; idle(); cmd_wr = 1; irq_src = 2'b11;
        repeat (3) tick();
        rst = 0;
        tick();
        check("reset_int_n",   {31'd0, int_n},     32'd1);
        check("reset_rd_data", {24'd0, rd_data},   32'hFF);
        check("reset_count",   {29'd0, cmd_count}, 32'd0);
        check("reset_pend",    {29'd0, irq_pend},  32'd0);
        check("reset_busy",    {31'd0, snd_busy},  32'd0);
        idle();
        tick();
        check("idle_pend", {29'd0, irq_pend}, 32'd0);

        for (int i = 0; i < tbl.size(); i++) begin
            cmd_wr = tbl[i].wr; cmd_din = tbl[i].din; rd_stb = tbl[i].rd;
            clr_stb = tbl[i].clr; irq_ack = tbl[i].ack; irq_src = 2'b00;
            tick();
            check($sformatf("vec%0d", i), outs(), exp_outs(tbl[i]));
        end

        // Reset mid-operation discards two queued entries and pending IRQ.
        idle();
        rst = 1;
        tick();
        rst = 0;
        check("midreset_count", {29'd0, cmd_count}, 32'd0);
        check("midreset_pend",  {29'd0, irq_pend},  32'd0);
        check("midreset_rd",    {24'd0, rd_data},   32'hFF);
        tick();

        // IRQ source edges, set-vs-ack race, held level, non-pending ack.
        irq_src = 2'b01;
        tick();
        check("src0_edge_pend", {29'd0, irq_pend}, 32'b010);
        irq_src = 2'b00;
        tick();
        irq_src = 2'b01; irq_ack = 3'b010;
        tick();
        check("race_pend",  {29'd0, irq_pend}, 32'b010);
        check("race_int_n", {31'd0, int_n},    32'd0);
        irq_ack = 3'b010;
        tick();
        check("ack_pend", {29'd0, irq_pend}, 32'b000);
        check("ack_int_n", {31'd0, int_n},   32'd1);
        irq_ack = 3'b000;
        repeat (3) tick();
        check("held_no_retrigger", {29'd0, irq_pend}, 32'b000);
        irq_src = 2'b11;
        tick();
        check("src1_edge_pend", {29'd0, irq_pend}, 32'b100);
        irq_ack = 3'b001;
        tick();
        check("ack_nonpending", {29'd0, irq_pend}, 32'b100);
        irq_ack = 3'b100;
        tick();
        check("ack_src1", {29'd0, irq_pend}, 32'b000);
        idle();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
